or_share_arbiter: RTL and testbench

Round-robin controller that shares one W-bit bank of 2-input OR gates among N requesters. Each requester presents two operand vectors and a request; the controller grants one requester at a time, registers its operands into the shared OR datapath, captures the result and returns it with a one-cycle done pulse. It sits between the gate library and any block needing occasional OR evaluation, so only one OR bank is built.

---
 rtl/or_share_arbiter.sv | 135 +++++++++++++
 tb/tb_or_share_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/or_share_arbiter.sv
// or_share_arbiter: round-robin controller that time-shares a single W-bit
// bank of 2-input OR gates among N requesters. Each transaction takes three
// states (IDLE arbitration, ISSUE through the OR bank, RESULT with a done
// pulse), so a continuously busy bank completes one operation every 3 cycles.
`timescale 1ns/1ps

module or_share_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [W-1:0]   c_out,
  output logic           busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic [W-1:0]  c_q, c_d;
  logic          busy_q, busy_d;

  logic          found;
  logic [PW-1:0] win;
  logic [W-1:0]  or_bank;
  int            cand;

  // The one shared OR bank: one 2-input gate per bit, fed only by the
  // operand registers so in-flight results ignore later input changes.
  for (genvar gi = 0; gi < W; gi++) begin : g_or_bank
    or u_or (or_bank[gi], a_q[gi], b_q[gi]);
  end

  // Round-robin search: first asserted req starting at ptr and wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr_q) + off) % N;
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        win   = cand[PW-1:0];
      end
    end
  end

  // Next-state logic for the IDLE -> ISSUE -> RESULT transaction sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    c_d     = c_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d  = '0;
        done_d = '0;
        busy_d = 1'b0;
        if (found) begin
          a_d        = a_in[int'(win)*W +: W];
          b_d        = b_in[int'(win)*W +: W];
          gnt_d[win] = 1'b1;
          busy_d     = 1'b1;
          ptr_d      = (int'(win) == N-1) ? '0 : win + 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // gnt_q already holds onehot(winner), so it doubles as the done pattern.
        c_d     = or_bank;
        done_d  = gnt_q;
        state_d = ST_RESULT;
      end
      ST_RESULT: begin
        gnt_d   = '0;
        done_d  = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        done_d  = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any in-flight transaction with no done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign c_out = c_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_or_share_arbiter.sv
// Directed testbench for or_share_arbiter (N=4, W=8): inputs change and
// outputs are sampled 1 ns after each rising edge.
`timescale 1ns/1ps

module tb_or_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   c_out;
  logic           busy;

  int vectors = 0;
  int miscompares = 0;

  or_share_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .a_in  (a_in),
    .b_in  (b_in),
    .gnt   (gnt),
    .done  (done),
    .c_out (c_out),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[idx*W +: W] = a;
    b_in[idx*W +: W] = b;
  endtask

  // Synchronous-looking pulse of the reset with all inputs cleared.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    tick();
    rst_n = 1'b1;
  endtask

  // Advance until done is seen or the budget runs out; reports cycles taken.
  task automatic wait_done(input int limit, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < limit) begin
      tick();
      cycles++;
      if (done !== '0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({gnt, done, c_out, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: gnt=%b done=%b c_out=%h busy=%b required all 0", gnt, done, c_out, busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0001;
    set_ops(0, 8'h0F, 8'hA0);
    tick();
    vectors++;
    if (gnt !== 4'b0001 || done !== 4'b0000 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_issue: gnt=%b done=%b busy=%b required 0001 0000 1", gnt, done, busy);
    end
    tick();
    vectors++;
    if (gnt !== 4'b0001 || done !== 4'b0001 || c_out !== 8'hAF) begin
      miscompares++;
      $display("FAIL single_result: gnt=%b done=%b c_out=%h required 0001 0001 af", gnt, done, c_out);
    end
    req = '0;
    tick();
    vectors++;
    if (gnt !== '0 || done !== '0 || busy !== 1'b0 || c_out !== 8'hAF) begin
      miscompares++;
      $display("FAIL single_after: gnt=%b done=%b busy=%b c_out=%h required 0000 0000 0 af", gnt, done, busy, c_out);
    end
  endtask

  task automatic test_simultaneous();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] exp_c [4] = '{8'h10, 8'h21, 8'h42, 8'h83};
    bit ok;
    int cyc;
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, W'(i), 8'h10 << i);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_done(12, ok, cyc);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL simul_timeout: transaction %0d no done within 12 cycles", t);
      end else begin
        if (done !== (4'b0001 << order[t]) || gnt !== done || c_out !== exp_c[order[t]]) begin
          miscompares++;
          $display("FAIL simul_order: t=%0d done=%b gnt=%b c_out=%h required done=%b c_out=%h",
                   t, done, gnt, c_out, 4'b0001 << order[t], exp_c[order[t]]);
        end
        if (t > 0) begin
          vectors++;
          if (cyc != 3) begin
            miscompares++;
            $display("FAIL simul_rate: t=%0d cycles between dones=%0d required 3", t, cyc);
          end
        end
      end
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    int order [4] = '{3, 0, 2, 3};
    bit ok;
    int cyc;
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 8'h01 << i, 8'h80 >> i);
    req = 4'b0100;
    wait_done(12, ok, cyc);
    vectors++;
    if (!ok || done !== 4'b0100) begin
      miscompares++;
      $display("FAIL wrap_setup: done=%b ok=%0d required 0100", done, ok);
    end
    req = 4'b1101;
    for (int t = 0; t < 4; t++) begin
      wait_done(12, ok, cyc);
      vectors++;
      if (!ok || done !== (4'b0001 << order[t])) begin
        miscompares++;
        $display("FAIL wrap_order: t=%0d done=%b ok=%0d required %b", t, done, ok, 4'b0001 << order[t]);
      end
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_operand_change();
    do_reset();
    set_ops(1, 8'h01, 8'h02);
    req = 4'b0010;
    tick();
    vectors++;
    if (gnt !== 4'b0010) begin
      miscompares++;
      $display("FAIL opchg_grant: gnt=%b required 0010", gnt);
    end
    set_ops(1, 8'hFF, 8'h02);
    req = '0;
    tick();
    vectors++;
    if (done !== 4'b0010 || c_out !== 8'h03) begin
      miscompares++;
      $display("FAIL opchg_result: done=%b c_out=%h required 0010 03", done, c_out);
    end
    tick();
    a_in = '0;
    b_in = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    set_ops(2, 8'h11, 8'h22);
    req = 4'b0100;
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (gnt !== '0 || done !== '0 || busy !== 1'b0 || c_out !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_async: gnt=%b done=%b busy=%b c_out=%h required all 0", gnt, done, busy, c_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (done !== '0) begin
        miscompares++;
        $display("FAIL reset_mid_nodone: done=%b required 0000", done);
      end
    end
    rst_n = 1'b1;
    wait_done(12, ok, cyc);
    vectors++;
    if (!ok || done !== 4'b0100 || c_out !== 8'h33) begin
      miscompares++;
      $display("FAIL reset_mid_serve: done=%b c_out=%h ok=%0d required 0100 33", done, c_out, ok);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_idle_hold();
    bit ok;
    int cyc;
    set_ops(0, 8'h50, 8'h0A);
    req = 4'b0001;
    wait_done(12, ok, cyc);
    req = '0;
    vectors++;
    if (!ok || c_out !== 8'h5A) begin
      miscompares++;
      $display("FAIL idle_setup: c_out=%h ok=%0d required 5a", c_out, ok);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (c_out !== 8'h5A || gnt !== '0 || done !== '0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_hold: cycle %0d c_out=%h gnt=%b done=%b busy=%b required 5a 0000 0000 0",
                 i, c_out, gnt, done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_wrap();
    test_operand_change();
    test_reset_mid();
    test_idle_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
